// File: rtl/traffic_pkg.sv
// Shared types, default durations and lamp-decode helpers for the traffic phase timer.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G  = 3'd0,
        MAIN_Y  = 3'd1,
        ALL_RED = 3'd2,
        SIDE_G  = 3'd3,
        SIDE_Y  = 3'd4,
        PED     = 3'd5
    } phase_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COUNT = 3'd2,
        STEP  = 3'd3,
        FAULT = 3'd4
    } tstate_t;

    localparam int unsigned DEF_TICK_DIV = 50_000_000;
    localparam int unsigned DEF_W        = 8;
    localparam int unsigned DEF_T_MAIN_G = 20;
    localparam int unsigned DEF_T_YEL    = 3;
    localparam int unsigned DEF_T_ALLRED = 1;
    localparam int unsigned DEF_T_SIDE_G = 10;
    localparam int unsigned DEF_T_PED    = 8;

    function automatic phase_t decode_phase(input logic ped, input logic mg, input logic my,
                                            input logic sg, input logic sy);
        phase_t p;
        if (ped)     p = PED;
        else if (mg) p = MAIN_G;
        else if (my) p = MAIN_Y;
        else if (sg) p = SIDE_G;
        else if (sy) p = SIDE_Y;
        else         p = ALL_RED;
        return p;
    endfunction

    // Two vehicle lamps at once, or the walk lamp alongside any vehicle lamp.
    function automatic logic lamps_illegal(input logic ped, input logic mg, input logic my,
                                           input logic sg, input logic sy);
        logic multi;
        multi = (mg & my) | (mg & sg) | (mg & sy) | (my & sg) | (my & sy) | (sg & sy);
        return multi | (ped & (mg | my | sg | sy));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; the count freezes while run is low.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer that times each sequencer phase and pulses step on expiry.
// Define TRAFFIC_ACTUATED_EN to hold main green until a side-street vehicle is seen.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned W        = DEF_W,
    parameter int unsigned T_MAIN_G = DEF_T_MAIN_G,
    parameter int unsigned T_YEL    = DEF_T_YEL,
    parameter int unsigned T_ALLRED = DEF_T_ALLRED,
    parameter int unsigned T_SIDE_G = DEF_T_SIDE_G,
    parameter int unsigned T_PED    = DEF_T_PED
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         run,
    input  logic         MG,
    input  logic         MY,
    input  logic         SG,
    input  logic         SY,
    input  logic         pedLight,
    input  logic         sideCar,
    output logic         step,
    output logic         tick,
    output logic [W-1:0] remaining,
    output logic         phaseErr,
    output tstate_t      state_dbg
);

    tstate_t      state_q, state_d;
    phase_t       phase_q, phase_d;
    logic [W-1:0] rem_q, rem_d;
    logic         err_q, err_d;
    phase_t       dec_phase;
    logic         illegal;
    logic         hold_green;
    logic         side_latch_q;

    function automatic logic [W-1:0] dur_of(input phase_t p);
        int unsigned v;
        case (p)
            MAIN_G:          v = T_MAIN_G;
            MAIN_Y, SIDE_Y:  v = T_YEL;
            SIDE_G:          v = T_SIDE_G;
            PED:             v = T_PED;
            default:         v = T_ALLRED;
        endcase
        if (v == 0) v = 1;
        return W'(v);
    endfunction

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .tick    (tick)
    );

    assign dec_phase = decode_phase(pedLight, MG, MY, SG, SY);
    assign illegal   = lamps_illegal(pedLight, MG, MY, SG, SY);

`ifdef TRAFFIC_ACTUATED_EN
    logic side_latch_d;

    // Clearing on a SIDE_G load wins over a same-cycle detection.
    always_comb begin
        side_latch_d = side_latch_q;
        if (state_q == LOAD && !illegal && dec_phase == SIDE_G) begin
            side_latch_d = 1'b0;
        end else if (sideCar && phase_q != SIDE_G) begin
            side_latch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) side_latch_q <= 1'b0;
        else          side_latch_q <= side_latch_d;
    end

    assign hold_green = (phase_q == MAIN_G) && !side_latch_q;
`else
    logic unused_fixed;
    assign side_latch_q = 1'b0;
    assign hold_green   = 1'b0;
    assign unused_fixed = sideCar ^ (^phase_q) ^ side_latch_q;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = LOAD;
            end
            LOAD: begin
                phase_d = dec_phase;
                rem_d   = dur_of(dec_phase);
                if (illegal) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                end else begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (illegal) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                end else if (rem_q == '0) begin
                    // Only reachable while holding actuated green (or a zero-width duration).
                    if (!hold_green) state_d = STEP;
                end else if (tick) begin
                    rem_d = rem_q - W'(1);
                    if (rem_q == W'(1) && !hold_green) state_d = STEP;
                end
            end
            STEP:    state_d = LOAD;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= MAIN_G;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign step      = (state_q == STEP);
    assign remaining = rem_q;
    assign phaseErr  = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer with a behavioural sequencer advanced by step.
module tb_traffic_phase_timer;
    import traffic_pkg::*;

    localparam int unsigned W = 8;
    localparam logic [W-1:0] SKIP = 8'hFF;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         run;
    logic         MG, MY, SG, SY, pedLight;
    logic         sideCar;
    logic         step, tick, phaseErr;
    logic [W-1:0] remaining;
    tstate_t      state_dbg;

    int           seq_idx = 0;
    logic         frc_mg = 1'b0;
    logic         frc_sg = 1'b0;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    int           mon_ticks = 0;

    traffic_phase_timer #(
        .TICK_DIV (4),
        .W        (W),
        .T_MAIN_G (5),
        .T_YEL    (2),
        .T_ALLRED (1),
        .T_SIDE_G (3),
        .T_PED    (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .MG        (MG),
        .MY        (MY),
        .SG        (SG),
        .SY        (SY),
        .pedLight  (pedLight),
        .sideCar   (sideCar),
        .step      (step),
        .tick      (tick),
        .remaining (remaining),
        .phaseErr  (phaseErr),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Sequencer model: MG, MY, all-red, SG, SY, all-red, repeat.
    always @(posedge clk) begin
        if (step) seq_idx <= (seq_idx == 5) ? 0 : seq_idx + 1;
    end
    assign MG       = (seq_idx == 0) | frc_mg;
    assign MY       = (seq_idx == 1);
    assign SG       = (seq_idx == 3) | frc_sg;
    assign SY       = (seq_idx == 4);
    assign pedLight = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each step pops the expected tick count for the phase just ended.
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_ticks = 0;
        end else begin
            if (step) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_step: got step at %0t expected none", $time);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (e != SKIP) chk("step_tick_spacing", mon_ticks, e);
                end
                mon_ticks = 0;
            end
            if (tick) mon_ticks++;
        end
    end

    // Driver tasks
    task automatic wait_steps(input int n, input int budget, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (step) seen++;
        end
        chk(name, seen, n);
    endtask

    task automatic wait_remaining(input logic [W-1:0] val, input int budget, input string name);
        int cyc = 0;
        @(posedge clk); #1;
        while (remaining != val && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(name, remaining, val);
    endtask

    task automatic to_count();
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cyc;
        int ticks;
        int bad;
        logic [W-1:0] snap;

        reset_n = 1'b0;
        run     = 1'b1;
`ifdef TRAFFIC_ACTUATED_EN
        sideCar = 1'b1;
`else
        sideCar = 1'b0;
`endif
        repeat (5) @(posedge clk);
        #1;
        chk("reset_step", step, 0);
        chk("reset_tick", tick, 0);
        chk("reset_remaining", remaining, 0);
        chk("reset_phaseErr", phaseErr, 0);

        // Full fixed-time cycle: MG, MY, AR, SG, SY, AR.
        exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(1);
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) chk("load_remaining_main_g", remaining, 5);
            if (step) break;
        end
        chk("first_step_in_window", (cyc >= 17 && cyc <= 20), 1);
        to_count();
        chk("remaining_main_y", remaining, 2);
        chk("model_main_y", seq_idx, 1);
        wait_steps(5, 200, "full_cycle_steps");
        @(posedge clk); #1;
        chk("model_back_to_mg", seq_idx, 0);

        // Pause at remaining=3 in MAIN_G.
        exp_q.push_back(5);
        wait_remaining(3, 60, "reach_remaining_3");
        run = 1'b0;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (tick || step) bad++;
            if (remaining != 3) bad += 100;
        end
        chk("pause_no_activity", bad % 100, 0);
        chk("pause_remaining_held", bad / 100, 0);
        run = 1'b1;
        ticks = 0;
        cyc = 0;
        while (!step && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (tick) ticks++;
        end
        chk("resume_ticks_to_step", ticks, 3);

        // Mid-count reset in SIDE_G at remaining=2.
        exp_q.push_back(2); exp_q.push_back(1);
        wait_steps(2, 100, "reach_side_g");
        to_count();
        chk("model_side_g", seq_idx, 3);
        wait_remaining(2, 40, "reach_side_g_2");
        reset_n = 1'b0;
        #1;
        chk("midreset_step", step, 0);
        chk("midreset_tick", tick, 0);
        chk("midreset_remaining", remaining, 0);
        chk("midreset_phaseErr", phaseErr, 0);
        sideCar = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(3);
        reset_n = 1'b1;
        to_count();
        chk("reload_side_g_remaining", remaining, 3);
        wait_steps(1, 60, "side_g_step_after_reset");

`ifdef TRAFFIC_ACTUATED_EN
        // Actuated hold: no vehicle means MAIN_G sits at zero.
        exp_q.push_back(2); exp_q.push_back(1);
        wait_steps(2, 100, "reach_main_g_actuated");
        exp_q.push_back(SKIP);
        wait_remaining(0, 100, "main_g_reaches_zero");
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (step || remaining != 0) bad++;
        end
        chk("actuated_hold", bad, 0);
        @(negedge clk);
        sideCar = 1'b1;
        @(posedge clk); #1;
        sideCar = 1'b0;
        cyc = 1;
        while (!step && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sidecar_to_step_clks", cyc, 2);
`endif

        // Illegal lamps during COUNT.
        to_count();
        chk("illegal_pre_state_count", state_dbg, COUNT);
        frc_mg = 1'b1;
        frc_sg = 1'b1;
        snap = remaining;
        @(posedge clk); #1;
        chk("phaseErr_set", phaseErr, 1);
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (!phaseErr || step || remaining != snap) bad++;
        end
        chk("fault_holds", bad, 0);
        frc_mg = 1'b0;
        frc_sg = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (step || !phaseErr) bad++;
        end
        chk("fault_terminal", bad, 0);
        reset_n = 1'b0;
        #1;
        chk("reset_clears_phaseErr", phaseErr, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
